sttxbuf: RTL and testbench
==========================

# sttxbuf

Transmit buffer and UART serializer directly downstream of the science-stream framer. It accepts the framer's byte stream on a write strobe and stores it in a 2^PTRWIDTH-byte FIFO. It returns the FIFO fill level `uw` to the framer, which uses it for admission control. It drains the FIFO onto a single 8N1 UART line, LSB first.

## Interface
Parameters:
- PTRWIDTH, 12, FIFO address width; DEPTH = 2^PTRWIDTH bytes
- BAUDDIV, 434, clk cycles per UART bit, ≥ 2 (434 = 50 MHz / 115200)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- wr  in  1  write strobe (framer `valid`); one byte per cycle while high
- wdata  in  8  write byte (framer `dout`)
- clr_ovf  in  1  synchronous clear of `ovf`
- uw  out  PTRWIDTH+1  bytes currently stored, 0..DEPTH
- full  out  1  uw == DEPTH
- empty  out  1  uw == 0
- ovf  out  1  sticky; a write was dropped because the FIFO was full
- tx  out  1  UART line, idle high
- busy  out  1  serializer not in IDLE

## Operation
- FIFO pointers are PTRWIDTH+1 bits. Address = low PTRWIDTH bits. The MSB marks wrap.
- uw = wptr − rptr, modulo 2^(PTRWIDTH+1). Full/empty derive from uw only.
- Write: when `wr && !full`, store `wdata` at wptr and increment wptr.
- Write while full: the byte is dropped, wptr is unchanged and `ovf` is set.
- `ovf` clears only on `clr_ovf` or reset. If a dropped write and `clr_ovf` occur in the same cycle, `ovf` ends at 1 (set wins).
- Read: a pop increments rptr. Memory read is synchronous, so data is valid the cycle after the pop.
- A simultaneous write and pop are both performed. uw is unchanged. On the full boundary, a write in the same cycle as a pop is still rejected, because `full` is evaluated before the pop.
- Serializer FSM:
  - IDLE: tx=1. If !empty, pop and go to LOAD.
  - LOAD: capture the read data into the shift register, clear the bit counter and baud counter, go to START.
  - START: tx=0 for BAUDDIV cycles, then go to DATA.
  - DATA: tx = shreg[0] for BAUDDIV cycles per bit. Shift right after each bit. After 8 bits go to STOP.
  - STOP: tx=1 for BAUDDIV cycles, then go to IDLE.
- Any unencoded state returns to IDLE with tx=1.
- `busy` = (state != IDLE).

## Timing
- Reset values: uw=0, full=0, empty=1, ovf=0, tx=1, busy=0, FSM=IDLE, both pointers=0. Memory contents are not reset.
- Write at cycle N updates uw/full/empty at N+1.
- Write into an empty FIFO at cycle N:
  - empty=0 at N+1
  - pop in IDLE at N+1
  - LOAD at N+2
  - tx falls at N+3
- Frame length: 10·BAUDDIV cycles from tx falling to the end of STOP.
- Back-to-back bytes: IDLE+LOAD add 2 cycles, so the frame period is 10·BAUDDIV+2 cycles.
- uw decrements in the cycle after the IDLE pop, i.e. uw reflects the pop by the LOAD cycle.
- Reset mid-frame: tx goes high immediately (asynchronously) and the FIFO is emptied. There is no partial-frame completion.
- Pointers wrap after 2^(PTRWIDTH+1) operations with no special handling.

## Structure
- Shared package holds the serializer state one-hot localparams (IDLE, LOAD, START, DATA, STOP) and the exp2 depth function used with the framer.
- One sub-module: `sfifo_byte`. It holds the pointers, uw/full/empty/ovf and a synchronous RAM, so it maps to block RAM.
- The top level holds the FSM, baud counter (0..BAUDDIV−1), bit counter (0..7) and shift register.

## Test plan
All scenarios use PTRWIDTH=3 and BAUDDIV=4.
- Reset, then idle 50 cycles -> tx=1, uw=0, empty=1, busy=0 throughout.
- Single write 0xA5 at cycle N -> tx falls at N+3. Each bit lasts 4 cycles. Bit pattern is 0,1,0,1,0,0,1,0,1, then stop 1. uw goes 0→1→0.
- Burst of framer header EB 90 00 76 on consecutive cycles -> uw peaks at 3 or 4. Bytes are emitted in order with a 42-cycle frame period. empty=1 after the last stop bit.
- 10 consecutive writes 0x00..0x09 while the serializer is busy with an earlier byte -> full=1 at uw=8. Excess writes are dropped and ovf=1. Only the first 8 bytes are transmitted. `clr_ovf` clears ovf.
- Simultaneous write and IDLE pop when uw=1 -> uw stays 1 and data order is preserved.
- Assert rst_n low mid-DATA -> tx=1 and uw=0 at once. After release, a fresh write 0x3C transmits correctly.

Source files
------------

// File: rtl/sttxbuf_pkg.sv
// Shared definitions for the science-stream transmit buffer: serializer states
// and the depth helper also used by the framer.
package sttxbuf_pkg;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_LOAD  = 5'b00010,
    ST_START = 5'b00100,
    ST_DATA  = 5'b01000,
    ST_STOP  = 5'b10000
  } tx_state_e;

  localparam logic [2:0] LAST_BIT = 3'd7;

  function automatic int unsigned exp2(input int unsigned w);
    return 32'd1 << w;
  endfunction

endpackage

// File: rtl/sfifo_byte.sv
// Byte FIFO with wrap-bit pointers, fill level and sticky overflow; storage is a
// synchronous-read RAM so it maps onto block RAM.
module sfifo_byte
  import sttxbuf_pkg::*;
#(
  parameter int unsigned PTRWIDTH = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_i,
  input  logic [7:0]        wdata_i,
  input  logic              rd_i,
  input  logic              clr_ovf_i,
  output logic [7:0]        rdata_o,
  output logic [PTRWIDTH:0] uw_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              ovf_o
);

  localparam int unsigned DEPTH = exp2(PTRWIDTH);

  logic [7:0]        mem_q [DEPTH];
  logic [PTRWIDTH:0] wptr_q, wptr_d;
  logic [PTRWIDTH:0] rptr_q, rptr_d;
  logic              ovf_q, ovf_d;
  logic              we, re;

  assign uw_o    = wptr_q - rptr_q;
  assign full_o  = (uw_o == (PTRWIDTH+1)'(DEPTH));
  assign empty_o = (uw_o == '0);
  assign ovf_o   = ovf_q;

  // full is taken before any same-cycle pop, so a write on the full boundary drops
  assign we = wr_i && !full_o;
  assign re = rd_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    if (we) wptr_d = wptr_q + 1'b1;
    if (re) rptr_d = rptr_q + 1'b1;
    if (clr_ovf_i) ovf_d = 1'b0;
    if (wr_i && full_o) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[wptr_q[PTRWIDTH-1:0]] <= wdata_i;
    if (re) rdata_o <= mem_q[rptr_q[PTRWIDTH-1:0]];
  end

endmodule

// File: rtl/sttxbuf.sv
// Transmit buffer for the science-stream framer: byte FIFO drained onto an
// 8N1 UART line, LSB first.
module sttxbuf
  import sttxbuf_pkg::*;
#(
  parameter int unsigned PTRWIDTH = 12,
  parameter int unsigned BAUDDIV  = 434
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [7:0]        wdata,
  input  logic              clr_ovf,
  output logic [PTRWIDTH:0] uw,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned BW = $clog2(BAUDDIV);

  tx_state_e  state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    rdata;
  logic          pop;
  logic          baud_last;

  sfifo_byte #(
    .PTRWIDTH(PTRWIDTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_i      (wr),
    .wdata_i   (wdata),
    .rd_i      (pop),
    .clr_ovf_i (clr_ovf),
    .rdata_o   (rdata),
    .uw_o      (uw),
    .full_o    (full),
    .empty_o   (empty),
    .ovf_o     (ovf)
  );

  assign baud_last = (baud_q == BW'(BAUDDIV - 1));
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    tx      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sh_d    = rdata;
        bit_d   = '0;
        baud_d  = '0;
        state_d = ST_START;
      end
      ST_START: begin
        tx = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        tx = sh_q[0];
        if (baud_last) begin
          baud_d = '0;
          sh_d   = {1'b0, sh_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == LAST_BIT) state_d = ST_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

endmodule

// File: tb/tb_sttxbuf.sv
// Directed bench for sttxbuf with PTRWIDTH=3, BAUDDIV=4: a line monitor decodes
// UART frames from tx and the test compares them with hand-computed frames.
module tb_sttxbuf;

  localparam int unsigned PW = 3;
  localparam int unsigned BD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr = 1'b0;
  logic [7:0]    wdata = '0;
  logic          clr_ovf = 1'b0;
  logic [PW:0]   uw;
  logic          full, empty, ovf, tx, busy;

  sttxbuf #(
    .PTRWIDTH(PW),
    .BAUDDIV (BD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (wr),
    .wdata   (wdata),
    .clr_ovf (clr_ovf),
    .uw      (uw),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // frame[0] = start bit, frame[8:1] = data LSB first, frame[9] = stop bit
  typedef struct packed {
    logic [7:0] din;
    logic [9:0] frame;
  } vec_t;

  vec_t        vt [6];
  logic [9:0]  bfr [4];
  logic [9:0]  rxq [$];
  int          fallq [$];
  int          tests = 0;
  int          fails = 0;
  int          n;
  int          peak;
  logic [9:0]  f;

  initial begin : line_monitor
    logic [9:0] fr;
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        fallq.push_back(cyc);
        repeat (2) @(negedge clk);
        fr[0] = tx;
        for (int k = 1; k < 10; k++) begin
          repeat (BD) @(negedge clk);
          fr[k] = tx;
        end
        rxq.push_back(fr);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, fails so far %0d", fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_frames(input int cnt, input int budget);
    int k = 0;
    while (rxq.size() < cnt && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("frame_count", 32'(rxq.size()), 32'(cnt));
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin : stim
    vt[0] = '{din: 8'hA5, frame: 10'b1101001010};
    vt[1] = '{din: 8'h3C, frame: 10'b1001111000};
    vt[2] = '{din: 8'hFF, frame: 10'b1111111110};
    vt[3] = '{din: 8'h00, frame: 10'b1000000000};
    vt[4] = '{din: 8'h01, frame: 10'b1000000010};
    vt[5] = '{din: 8'h80, frame: 10'b1100000000};
    bfr[0] = 10'b1111010110;  // EB
    bfr[1] = 10'b1100100000;  // 90
    bfr[2] = 10'b1000000000;  // 00
    bfr[3] = 10'b1011101100;  // 76

    // reset values, then 50 idle cycles
    #12;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_uw", 32'(uw), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_tx", 32'(tx), 32'd1);
      chk("idle_uw", 32'(uw), 32'd0);
      chk("idle_empty", 32'(empty), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // single-byte vectors
    for (int i = 0; i < 6; i++) begin
      rxq.delete();
      fallq.delete();
      wr = 1'b1;
      wdata = vt[i].din;
      n = cyc;
      @(negedge clk);
      wr = 1'b0;
      chk("vec_uw_n1", 32'(uw), 32'd1);
      chk("vec_empty_n1", 32'(empty), 32'd0);
      chk("vec_busy_n1", 32'(busy), 32'd0);
      @(negedge clk);
      chk("vec_uw_load", 32'(uw), 32'd0);
      chk("vec_busy_load", 32'(busy), 32'd1);
      wait_frames(1, 60);
      if (rxq.size() > 0) begin
        chk("vec_frame", 32'(rxq[0]), 32'(vt[i].frame));
        chk("vec_latency", 32'(fallq[0] - n), 32'd3);
      end
      wait_idle(60);
      chk("vec_empty_end", 32'(empty), 32'd1);
    end

    // framer header burst
    rxq.delete();
    fallq.delete();
    peak = 0;
    n = cyc;
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1;
      wdata = bfr[i][8:1];
      @(negedge clk);
      if (int'(uw) > peak) peak = int'(uw);
    end
    wr = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (int'(uw) > peak) peak = int'(uw);
    end
    chk("burst_peak", 32'(peak), 32'd3);
    wait_frames(4, 250);
    if (rxq.size() == 4) begin
      chk("burst_latency", 32'(fallq[0] - n), 32'd3);
      for (int i = 0; i < 4; i++) chk("burst_frame", 32'(rxq[i]), 32'(bfr[i]));
      for (int i = 1; i < 4; i++) chk("burst_period", 32'(fallq[i] - fallq[i-1]), 32'd42);
    end
    wait_idle(60);
    chk("burst_empty", 32'(empty), 32'd1);

    // overflow while the serializer is busy
    rxq.delete();
    fallq.delete();
    wr = 1'b1;
    wdata = 8'h55;
    @(negedge clk);
    wr = 1'b0;
    repeat (2) @(negedge clk);
    chk("ovf_pre_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      wr = 1'b1;
      wdata = 8'(i);
      @(negedge clk);
      if (i == 7) begin
        chk("ovf_full_uw", 32'(uw), 32'd8);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_not_yet", 32'(ovf), 32'd0);
      end
    end
    wr = 1'b0;
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_uw_hold", 32'(uw), 32'd8);
    wr = 1'b1;
    wdata = 8'hEE;
    clr_ovf = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    chk("ovf_set_wins", 32'(ovf), 32'd1);
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovf_clear", 32'(ovf), 32'd0);
    // write while full in the same cycle as the IDLE pop
    begin
      int k = 0;
      while (busy && k < 60) begin
        @(negedge clk);
        k++;
      end
    end
    chk("ovf_pop_idle", 32'(busy), 32'd0);
    wr = 1'b1;
    wdata = 8'hEE;
    @(negedge clk);
    wr = 1'b0;
    chk("ovf_pop_uw", 32'(uw), 32'd7);
    chk("ovf_pop_reject", 32'(ovf), 32'd1);
    chk("ovf_pop_full", 32'(full), 32'd0);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    wait_frames(9, 500);
    for (int i = 0; i < rxq.size(); i++) begin
      f = rxq[i];
      chk("ovf_start", 32'(f[0]), 32'd0);
      chk("ovf_stop", 32'(f[9]), 32'd1);
      chk("ovf_data", 32'(f[8:1]), (i == 0) ? 32'h55 : 32'(i - 1));
    end
    wait_idle(60);
    repeat (50) @(negedge clk);
    chk("ovf_nframes", 32'(rxq.size()), 32'd9);
    chk("ovf_empty", 32'(empty), 32'd1);

    // simultaneous write and IDLE pop at uw=1
    rxq.delete();
    fallq.delete();
    wr = 1'b1;
    wdata = 8'h11;
    @(negedge clk);
    wdata = 8'h22;
    chk("sim_uw_n1", 32'(uw), 32'd1);
    @(negedge clk);
    wr = 1'b0;
    chk("sim_uw_n2", 32'(uw), 32'd1);
    wait_frames(2, 150);
    if (rxq.size() == 2) begin
      chk("sim_frame0", 32'(rxq[0]), 32'(10'b1000100010));
      chk("sim_frame1", 32'(rxq[1]), 32'(10'b1001000100));
    end
    wait_idle(60);

    // reset mid-DATA
    rxq.delete();
    fallq.delete();
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1;
      wdata = 8'hA5 + 8'(i);
      @(negedge clk);
    end
    wr = 1'b0;
    begin
      int k = 0;
      while (fallq.size() == 0 && k < 20) begin
        @(negedge clk);
        k++;
      end
    end
    repeat (12) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_uw", 32'(uw), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tx", 32'(tx), 32'd1);
    chk("arst_uw", 32'(uw), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_rst_uw", 32'(uw), 32'd0);
    chk("post_rst_tx", 32'(tx), 32'd1);
    rxq.delete();
    fallq.delete();
    wr = 1'b1;
    wdata = 8'h3C;
    n = cyc;
    @(negedge clk);
    wr = 1'b0;
    wait_frames(1, 60);
    if (rxq.size() > 0) begin
      chk("post_rst_frame", 32'(rxq[0]), 32'(10'b1001111000));
      chk("post_rst_latency", 32'(fallq[0] - n), 32'd3);
    end
    wait_idle(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
